// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of a 5-stage RISC-V style pipeline plus the EX/MEM
// pipeline register. Computes the ALU result, branch/jump redirect and the
// registered control/data handed to the MEM stage.
// Optional feature: define EXECUTE_FORWARDING_EN to enable the operand
// forwarding muxes. In the default build, ForwardAE/ForwardBE/ResultW are
// accepted but ignored.
module execute_cycle #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic              MemWriteE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic [1:0]        ResultSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [4:0]        RD_E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [4:0]        RD_M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M
);

  // ALU: arithmetic wraps modulo 2^DATA_W; slt compares as two's complement.
  function automatic logic [DATA_W-1:0] alu_fn(
    input logic [2:0]               ctl,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    case (ctl)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b101:  r = {{(DATA_W-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] src_a_p0;
  logic [DATA_W-1:0] write_data_p0;
  logic [DATA_W-1:0] src_b_p0;
  logic [DATA_W-1:0] alu_result_p0;
  logic              zero_p0;

  logic              reg_write_p1;
  logic              mem_write_p1;
  logic [1:0]        result_src_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] alu_result_p1;
  logic [DATA_W-1:0] write_data_p1;
  logic [DATA_W-1:0] pc_plus4_p1;

  // ---- EX stage (p0): operand selection, ALU, redirect ----
`ifdef EXECUTE_FORWARDING_EN
  // Operand A forwarding; M-stage value is the one registered on the last edge
  // (zero while in reset), so dependent back-to-back ops need no bubble.
  always_comb begin
    src_a_p0 = RD1_E;
    case (ForwardAE)
      2'b01:   src_a_p0 = ResultW;
      2'b10:   src_a_p0 = alu_result_p1;
      default: src_a_p0 = RD1_E;
    endcase
  end

  // Operand B / store data forwarding with the same encoding as operand A.
  always_comb begin
    write_data_p0 = RD2_E;
    case (ForwardBE)
      2'b01:   write_data_p0 = ResultW;
      2'b10:   write_data_p0 = alu_result_p1;
      default: write_data_p0 = RD2_E;
    endcase
  end
`else
  // Forwarding disabled: register-file operands pass straight through.
  assign src_a_p0      = RD1_E;
  assign write_data_p0 = RD2_E;
  logic unused_fwd;
  assign unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
`endif

  assign src_b_p0      = ALUSrcE ? Imm_Ext_E : write_data_p0;
  assign alu_result_p0 = alu_fn(ALUControlE, src_a_p0, src_b_p0);
  assign zero_p0       = (alu_result_p0 == '0);
  assign PCSrcE        = (BranchE & zero_p0) | JumpE;
  assign PCTargetE     = PCE + Imm_Ext_E;

  // ---- EX/MEM boundary (p1): async clear discards any in-flight instruction ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      result_src_p1 <= 2'b00;
      rd_p1         <= 5'd0;
      alu_result_p1 <= '0;
      write_data_p1 <= '0;
      pc_plus4_p1   <= '0;
    end else begin
      reg_write_p1  <= RegWriteE;
      mem_write_p1  <= MemWriteE;
      result_src_p1 <= ResultSrcE;
      rd_p1         <= RD_E;
      alu_result_p1 <= alu_result_p0;
      write_data_p1 <= write_data_p0;
      pc_plus4_p1   <= PCPlus4E;
    end
  end

  assign RegWriteM  = reg_write_p1;
  assign MemWriteM  = mem_write_p1;
  assign ResultSrcM = result_src_p1;
  assign RD_M       = rd_p1;
  assign ALUResultM = alu_result_p1;
  assign WriteDataM = write_data_p1;
  assign PCPlus4M   = pc_plus4_p1;

endmodule

// File: tb/tb_execute_cycle.sv
// Testbench for execute_cycle: scoreboard of expected M-stage values pushed
// when an EX-stage instruction is driven, popped after the capturing edge.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
  } m_t;

  m_t          sb[$];
  logic [31:0] model_am;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000: return a + b;
      3'b001: return a + (~b) + 32'd1;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: begin
        if (a[31] != b[31]) return {31'd0, a[31]};
        return {31'd0, (a < b)};
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_model(input logic [1:0] f, input logic [31:0] rd,
                                            input logic [31:0] rw, input logic [31:0] am);
`ifdef EXECUTE_FORWARDING_EN
    if (f == 2'b01) return rw;
    if (f == 2'b10) return am;
    return rd;
`else
    return rd;
`endif
  endfunction

  function automatic logic [31:0] exp_alu();
    logic [31:0] a, wd, b;
    a  = fwd_model(ForwardAE, RD1_E, ResultW, model_am);
    wd = fwd_model(ForwardBE, RD2_E, ResultW, model_am);
    b  = ALUSrcE ? Imm_Ext_E : wd;
    return alu_model(ALUControlE, a, b);
  endfunction

  task automatic clear_inputs();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
    ResultSrcE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    PCE = 0; PCPlus4E = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  task automatic check_m_zero(input string name);
    tests++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M} !== '0) begin
      fails++;
      $display("FAIL %s: M outputs alu=%h wd=%h pc4=%h rw=%b mw=%b rs=%b rd=%0d, required all 0",
               name, ALUResultM, WriteDataM, PCPlus4M, RegWriteM, MemWriteM, ResultSrcM, RD_M);
    end
  endtask

  // Drive the current inputs for one cycle: check combinational redirect now,
  // push expected M-stage values, compare them after the capturing edge.
  task automatic step(input string name);
    m_t e;
    logic [31:0] alu;
    logic [31:0] wd;
    alu = exp_alu();
    wd  = fwd_model(ForwardBE, RD2_E, ResultW, model_am);
    #1;
    tests++;
    if (PCSrcE !== ((BranchE && alu == 32'd0) || JumpE)) begin
      fails++;
      $display("FAIL %s pcsrc: got %b, required %b", name, PCSrcE, ((BranchE && alu == 32'd0) || JumpE));
    end
    tests++;
    if (PCTargetE !== PCE + Imm_Ext_E) begin
      fails++;
      $display("FAIL %s pctarget: got %h, required %h", name, PCTargetE, PCE + Imm_Ext_E);
    end
    e.alu = alu; e.wd = wd; e.pc4 = PCPlus4E; e.rw = RegWriteE;
    e.mw = MemWriteE; e.rs = ResultSrcE; e.rd = RD_E;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: got empty queue, required 1 entry", name);
    end else begin
      e = sb.pop_front();
      if (ALUResultM !== e.alu) begin
        fails++;
        $display("FAIL %s alu: got %h, required %h", name, ALUResultM, e.alu);
      end
      tests++;
      if (WriteDataM !== e.wd) begin
        fails++;
        $display("FAIL %s wdata: got %h, required %h", name, WriteDataM, e.wd);
      end
      tests++;
      if ({PCPlus4M, RegWriteM, MemWriteM, ResultSrcM, RD_M} !== {e.pc4, e.rw, e.mw, e.rs, e.rd}) begin
        fails++;
        $display("FAIL %s ctrl: got pc4=%h rw=%b mw=%b rs=%b rd=%0d, required pc4=%h rw=%b mw=%b rs=%b rd=%0d",
                 name, PCPlus4M, RegWriteM, MemWriteM, ResultSrcM, RD_M,
                 e.pc4, e.rw, e.mw, e.rs, e.rd);
      end
      model_am = e.alu;
    end
  endtask

  task automatic test_reset();
    logic exp_pcsrc;
    clear_inputs();
    rst = 0;
    model_am = 0;
    #2;
    check_m_zero("reset_initial");
    // Busy inputs with clock edges must not load while held in reset.
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b11; RD_E = 5'd9;
    RD1_E = 32'h1234; RD2_E = 32'h55; PCPlus4E = 32'h44;
    @(posedge clk); #1;
    check_m_zero("reset_no_load");
    // Forward select 10 during reset yields 0; observe via zero-flag branch.
    ForwardAE = 2'b10; BranchE = 1; ALUSrcE = 1; Imm_Ext_E = 0;
    ALUControlE = 3'b000; RD1_E = 32'd5; PCE = 32'h200;
    exp_pcsrc = (exp_alu() == 32'd0);
    #1;
    tests++;
    if (PCSrcE !== exp_pcsrc) begin
      fails++;
      $display("FAIL reset_fwd_pcsrc: got %b, required %b", PCSrcE, exp_pcsrc);
    end
    tests++;
    if (PCTargetE !== 32'h200) begin
      fails++;
      $display("FAIL reset_pctarget: got %h, required %h", PCTargetE, 32'h200);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_add_imm();
    clear_inputs();
    RD1_E = 32'd5; Imm_Ext_E = 32'hFFFF_FFFF; ALUSrcE = 1; ALUControlE = 3'b000;
    RegWriteE = 1; RD_E = 5'd3; PCPlus4E = 32'h14; ResultSrcE = 2'b01;
    step("add_imm");
    tests++;
    if (ALUResultM !== 32'd4) begin
      fails++;
      $display("FAIL add_imm_const: got %h, required %h", ALUResultM, 32'd4);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchE = 1; RD1_E = 32'd7; RD2_E = 32'd7; ALUControlE = 3'b001;
    PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF8;
    #1;
    tests++;
    if ({PCSrcE, PCTargetE} !== {1'b1, 32'h0000_00F8}) begin
      fails++;
      $display("FAIL branch_taken: got pcsrc=%b tgt=%h, required pcsrc=1 tgt=000000f8", PCSrcE, PCTargetE);
    end
    step("branch_taken");
    RD2_E = 32'd8;
    #1;
    tests++;
    if (PCSrcE !== 1'b0) begin
      fails++;
      $display("FAIL branch_not_taken: got %b, required 0", PCSrcE);
    end
    step("branch_not_taken");
    BranchE = 0; JumpE = 1;
    step("jump");
  endtask

  task automatic test_forward();
    clear_inputs();
    RD1_E = 32'd10; Imm_Ext_E = 32'd3; ALUSrcE = 1; ALUControlE = 3'b000;
    RegWriteE = 1; RD_E = 5'd5;
    step("fwd_producer");
    ForwardAE = 2'b10; Imm_Ext_E = 32'd1;
    step("fwd_from_m");
    ForwardAE = 2'b01; ResultW = 32'h20;
    step("fwd_from_w");
    // Both paths select the same source.
    ForwardAE = 2'b10; ForwardBE = 2'b10; ALUSrcE = 0; ALUControlE = 3'b001;
    BranchE = 1; RD2_E = 32'd99;
    step("fwd_same_m");
    ForwardAE = 2'b01; ForwardBE = 2'b01; ALUControlE = 3'b011;
    step("fwd_same_w");
    ForwardAE = 2'b11; ForwardBE = 2'b11; RD1_E = 32'h0F0; RD2_E = 32'h00F;
    step("fwd_sel_11");
  endtask

  task automatic test_slt_store();
    clear_inputs();
    ALUControlE = 3'b101; RD1_E = 32'h8000_0000; RD2_E = 32'd1;
    step("slt_neg");
    tests++;
    if (ALUResultM !== 32'd1) begin
      fails++;
      $display("FAIL slt_const: got %h, required %h", ALUResultM, 32'd1);
    end
    RD1_E = 32'd1; RD2_E = 32'h8000_0000;
    step("slt_pos");
    clear_inputs();
    MemWriteE = 1; ALUSrcE = 1; RD2_E = 32'hDEAD_BEEF; RD1_E = 32'h1000; Imm_Ext_E = 32'h8;
    step("store");
    tests++;
    if ({WriteDataM, MemWriteM} !== {32'hDEAD_BEEF, 1'b1}) begin
      fails++;
      $display("FAIL store_const: got wd=%h mw=%b, required wd=deadbeef mw=1", WriteDataM, MemWriteM);
    end
  endtask

  task automatic test_alu_ops();
    clear_inputs();
    RD1_E = 32'hF0F0_1234; RD2_E = 32'h0FF0_4321;
    for (int c = 0; c < 8; c++) begin
      ALUControlE = c[2:0];
      step($sformatf("alu_op_%0d", c));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      RegWriteE   = 1'($urandom);
      MemWriteE   = 1'($urandom);
      ALUSrcE     = 1'($urandom);
      BranchE     = 1'($urandom);
      JumpE       = ($urandom_range(0, 3) == 0);
      ResultSrcE  = 2'($urandom);
      ALUControlE = 3'($urandom);
      RD1_E       = (i % 4 == 0) ? RD2_E : $urandom;
      RD2_E       = $urandom;
      Imm_Ext_E   = $urandom;
      PCE         = $urandom;
      PCPlus4E    = $urandom;
      RD_E        = 5'($urandom);
      ForwardAE   = 2'($urandom);
      ForwardBE   = 2'($urandom);
      ResultW     = $urandom;
      step($sformatf("b2b_%0d", i));
    end
  endtask

  task automatic test_mid_reset();
    clear_inputs();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10; RD_E = 5'd17;
    RD1_E = 32'd40; Imm_Ext_E = 32'd2; ALUSrcE = 1; RD2_E = 32'hAA; PCPlus4E = 32'h88;
    step("mid_load");
    #2;
    rst = 0;
    #1;
    check_m_zero("mid_reset_async");
    model_am = 0;
    @(posedge clk); #1;
    check_m_zero("mid_reset_hold");
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    model_am = ALUResultM == ALUResultM ? exp_alu() : 32'd0;
    // That edge loaded the held inputs; re-derive then run a forwarding op.
    tests++;
    if (ALUResultM !== 32'd42) begin
      fails++;
      $display("FAIL post_reset_load: got %h, required %h", ALUResultM, 32'd42);
    end
    model_am = 32'd42;
    ForwardAE = 2'b10; Imm_Ext_E = 32'd1;
    step("post_reset_fwd");
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_branch();
    test_forward();
    test_slt_store();
    test_alu_ops();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
